// File: rtl/gddr6_init_seq.sv
// Power-up and MRS initialization sequencer for one GDDR6 channel.
// Build option: define INIT_FAST_SIM_EN to shorten T_INIT1/2/3 to 8 cycles each.
module gddr6_init_seq #(
    parameter int unsigned  T_INIT1   = 1000,
    parameter int unsigned  T_INIT2   = 100,
    parameter int unsigned  T_INIT3   = 100,
    parameter int unsigned  T_MOD     = 16,
    parameter int unsigned  T_WCK     = 32,
    parameter int unsigned  NUM_MRS   = 4,
    parameter logic [191:0] MR_INIT   = 192'h0,
    parameter logic [1:0]   EDC_STRAP = 2'b00
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_phy_rdy,
    input  logic            i_intf_rdy,
    output logic            o_init_pkt_valid,
    output logic [15:0]     o_init_pkt,
    output logic [2:0]      o_init_cmd,
    output logic            o_init_ck_en,
    output logic            o_init_wck_en,
    output logic            o_init_done,
    output logic            o_reset_n,
    output logic [7:0]      o_init_cke_n,
    output logic [1:0][7:0] o_init_edc,
    output logic            o_edc_tri
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned OP_W  = 12;

`ifdef INIT_FAST_SIM_EN
    localparam int unsigned L_T_INIT1 = 8;
    localparam int unsigned L_T_INIT2 = 8;
    localparam int unsigned L_T_INIT3 = 8;
`else
    localparam int unsigned L_T_INIT1 = T_INIT1;
    localparam int unsigned L_T_INIT2 = T_INIT2;
    localparam int unsigned L_T_INIT3 = T_INIT3;
`endif

    localparam logic [CNT_W-1:0] LD_INIT1 = CNT_W'(L_T_INIT1 - 1);
    localparam logic [CNT_W-1:0] LD_INIT2 = CNT_W'(L_T_INIT2 - 1);
    localparam logic [CNT_W-1:0] LD_INIT3 = CNT_W'(L_T_INIT3 - 1);
    localparam logic [CNT_W-1:0] LD_MOD   = CNT_W'(T_MOD - 1);
    localparam logic [CNT_W-1:0] LD_WCK   = CNT_W'(T_WCK - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MRS);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_MRS = 3'd1;

    localparam logic [15:0][OP_W-1:0] MR_TAB   = MR_INIT;
    localparam logic [1:0][7:0]       EDC_RST  = {{8{EDC_STRAP[1]}}, {8{EDC_STRAP[0]}}};

    typedef enum logic [2:0] {
        S_WAIT_PHY,
        S_RESET,
        S_STRAP,
        S_STAB,
        S_MRS_REQ,
        S_MRS_GAP,
        S_WCK,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_valid, w_valid_nxt;
    logic [15:0]      r_pkt, w_pkt_nxt;
    logic [2:0]       r_cmd, w_cmd_nxt;
    logic             r_ck_en, w_ck_en_nxt;
    logic             r_wck_en, w_wck_en_nxt;
    logic             r_done, w_done_nxt;
    logic             r_reset_n, w_reset_n_nxt;
    logic             r_cke_n, w_cke_n_nxt;
    logic             r_edc_tri, w_edc_tri_nxt;
    logic [1:0][7:0]  r_edc;
    logic             w_cnt_zero;
    logic             w_dec;

    // Next-state, counter and registered-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_pkt_nxt     = r_pkt;
        w_cmd_nxt     = r_cmd;
        w_ck_en_nxt   = r_ck_en;
        w_wck_en_nxt  = r_wck_en;
        w_done_nxt    = r_done;
        w_reset_n_nxt = r_reset_n;
        w_cke_n_nxt   = r_cke_n;
        w_edc_tri_nxt = r_edc_tri;
        w_cnt_zero    = (r_cnt == '0);
        w_dec         = 1'b0;

        case (r_state)
            S_WAIT_PHY: begin
                if (i_phy_rdy) begin
                    w_cnt_nxt   = LD_INIT1;
                    w_ck_en_nxt = 1'b1;
                    w_state_nxt = S_RESET;
                end
            end
            S_RESET: begin
                if (w_cnt_zero) begin
                    w_reset_n_nxt = 1'b1;
                    w_cnt_nxt     = LD_INIT2;
                    w_state_nxt   = S_STRAP;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_STRAP: begin
                if (w_cnt_zero) begin
                    w_cke_n_nxt   = 1'b0;
                    w_edc_tri_nxt = 1'b1;
                    w_cnt_nxt     = LD_INIT3;
                    w_state_nxt   = S_STAB;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_STAB: begin
                if (w_cnt_zero) begin
                    // Packet is registered on entry so valid rises with the state.
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_cmd_nxt   = CMD_MRS;
                    w_pkt_nxt   = {4'h0, MR_TAB[4'h0]};
                    w_state_nxt = S_MRS_REQ;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_MRS_REQ: begin
                if (i_intf_rdy && r_valid) begin
                    w_valid_nxt = 1'b0;
                    w_cmd_nxt   = CMD_NOP;
                    w_pkt_nxt   = '0;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_cnt_nxt   = LD_MOD;
                    w_state_nxt = S_MRS_GAP;
                end
            end
            S_MRS_GAP: begin
                if (!w_cnt_zero) begin
                    w_dec = 1'b1;
                end else if (r_idx < IDX_LAST) begin
                    w_valid_nxt = 1'b1;
                    w_cmd_nxt   = CMD_MRS;
                    w_pkt_nxt   = {r_idx[3:0], MR_TAB[r_idx[3:0]]};
                    w_state_nxt = S_MRS_REQ;
                end else begin
                    w_wck_en_nxt = 1'b1;
                    w_cnt_nxt    = LD_WCK;
                    w_state_nxt  = S_WCK;
                end
            end
            S_WCK: begin
                if (w_cnt_zero) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_DONE: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_WAIT_PHY;
            end
        endcase

        if (w_dec) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_WAIT_PHY;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_pkt     <= '0;
            r_cmd     <= CMD_NOP;
            r_ck_en   <= 1'b0;
            r_wck_en  <= 1'b0;
            r_done    <= 1'b0;
            r_reset_n <= 1'b0;
            r_cke_n   <= 1'b1;
            r_edc_tri <= 1'b0;
            r_edc     <= EDC_RST;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_pkt     <= w_pkt_nxt;
            r_cmd     <= w_cmd_nxt;
            r_ck_en   <= w_ck_en_nxt;
            r_wck_en  <= w_wck_en_nxt;
            r_done    <= w_done_nxt;
            r_reset_n <= w_reset_n_nxt;
            r_cke_n   <= w_cke_n_nxt;
            r_edc_tri <= w_edc_tri_nxt;
            r_edc     <= r_edc;
        end
    end

    assign o_init_pkt_valid = r_valid;
    assign o_init_pkt       = r_pkt;
    assign o_init_cmd       = r_cmd;
    assign o_init_ck_en     = r_ck_en;
    assign o_init_wck_en    = r_wck_en;
    assign o_init_done      = r_done;
    assign o_reset_n        = r_reset_n;
    assign o_init_cke_n     = {8{r_cke_n}};
    assign o_init_edc       = r_edc;
    assign o_edc_tri        = r_edc_tri;

endmodule

// File: tb/tb_gddr6_init_seq.sv
// Self-checking bench for gddr6_init_seq: event-time reference model with random backpressure and resets.
module tb_gddr6_init_seq;

    localparam int T1 = 10;
    localparam int T2 = 5;
    localparam int T3 = 5;
    localparam int TM = 2;
    localparam int TW = 4;
    localparam int NM = 4;
    localparam logic [1:0]   STRAP = 2'b10;
    localparam logic [191:0] MR    = 192'h5A1_3C7_0F2_9E4_B6D_281_7AF_C30_4D9_E15_62B_A08_F73_19C_8E6_D2F;
    localparam int BUDGET = 400;

`ifdef INIT_FAST_SIM_EN
    localparam int E_T1 = 8;
    localparam int E_T2 = 8;
    localparam int E_T3 = 8;
`else
    localparam int E_T1 = T1;
    localparam int E_T2 = T2;
    localparam int E_T3 = T3;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            phy_rdy = 1'b0;
    logic            intf_rdy = 1'b0;
    logic            pkt_valid;
    logic [15:0]     pkt;
    logic [2:0]      cmd;
    logic            ck_en;
    logic            wck_en;
    logic            done;
    logic            reset_n;
    logic [7:0]      cke_n;
    logic [1:0][7:0] edc;
    logic            edc_tri;

    logic [15:0][11:0] mr_tab;
    logic [15:0]       exp_edc;
    int n_checks = 0;
    int n_fail   = 0;

    gddr6_init_seq #(
        .T_INIT1  (T1),
        .T_INIT2  (T2),
        .T_INIT3  (T3),
        .T_MOD    (TM),
        .T_WCK    (TW),
        .NUM_MRS  (NM),
        .MR_INIT  (MR),
        .EDC_STRAP(STRAP)
    ) u_dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_phy_rdy       (phy_rdy),
        .i_intf_rdy      (intf_rdy),
        .o_init_pkt_valid(pkt_valid),
        .o_init_pkt      (pkt),
        .o_init_cmd      (cmd),
        .o_init_ck_en    (ck_en),
        .o_init_wck_en   (wck_en),
        .o_init_done     (done),
        .o_reset_n       (reset_n),
        .o_init_cke_n    (cke_n),
        .o_init_edc      (edc),
        .o_edc_tri       (edc_tri)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_op(input int i);
        return mr_tab[4'(i)];
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_valid"},   32'(pkt_valid), 32'd0);
        check_eq({tag, "_pkt"},     32'(pkt),       32'd0);
        check_eq({tag, "_cmd"},     32'(cmd),       32'd0);
        check_eq({tag, "_ck_en"},   32'(ck_en),     32'd0);
        check_eq({tag, "_wck_en"},  32'(wck_en),    32'd0);
        check_eq({tag, "_done"},    32'(done),      32'd0);
        check_eq({tag, "_reset_n"}, 32'(reset_n),   32'd0);
        check_eq({tag, "_cke_n"},   32'(cke_n),     32'hFF);
        check_eq({tag, "_edc"},     32'(edc),       32'(exp_edc));
        check_eq({tag, "_edc_tri"}, 32'(edc_tri),   32'd0);
    endtask

    task automatic do_reset(input int idle);
        rst      = 1'b1;
        phy_rdy  = 1'b0;
        intf_rdy = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("rst");
        rst = 1'b0;
        for (int i = 0; i < idle; i++) begin
            intf_rdy = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_reset_vals("idle");
        end
    endtask

    // mode 0: ready always high; 1: 7-cycle stall on MRS 2; 2: random ready and phy_rdy.
    task automatic run_seq(input int mode, input int abort_idx, input int abort_t, output bit aborted);
        int t      = 0;
        int idx    = 0;
        int t_rst  = 1 + E_T1;
        int t_cke  = 1 + E_T1 + E_T2;
        int t_req  = 1 + E_T1 + E_T2 + E_T3;
        int t_wck  = -1;
        int t_done = -1;
        int bp     = 0;
        bit in_req, hs, ev;
        aborted = 1'b0;
        phy_rdy = 1'b1;
        while (1) begin
            in_req = (idx < NM) && (t >= t_req);
            case (mode)
                0: intf_rdy = 1'b1;
                1: begin
                    if (in_req && idx == 2 && bp < 7) begin
                        intf_rdy = 1'b0;
                        bp++;
                    end else begin
                        intf_rdy = 1'b1;
                    end
                end
                default: intf_rdy = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2 && t >= 1) phy_rdy = 1'($urandom_range(0, 1));
            hs = in_req && intf_rdy;
            @(posedge clk); #1;
            t++;
            if (hs) begin
                idx++;
                if (idx < NM) begin
                    t_req = t + TM;
                end else begin
                    t_wck  = t + TM;
                    t_done = t_wck + TW;
                end
            end
            ev = (idx < NM) && (t >= t_req);
            check_eq("ck_en",   32'(ck_en),   32'(t >= 1));
            check_eq("reset_n", 32'(reset_n), 32'(t >= t_rst));
            check_eq("cke_n",   32'(cke_n),   (t >= t_cke) ? 32'h00 : 32'hFF);
            check_eq("edc_tri", 32'(edc_tri), 32'(t >= t_cke));
            if (t < t_cke) check_eq("edc", 32'(edc), 32'(exp_edc));
            check_eq("valid",   32'(pkt_valid), 32'(ev));
            check_eq("cmd",     32'(cmd),       ev ? 32'd1 : 32'd0);
            if (ev) check_eq("pkt", 32'(pkt), 32'({4'(idx), exp_op(idx)}));
            check_eq("wck_en",  32'(wck_en), 32'(t_wck >= 0 && t >= t_wck));
            check_eq("done",    32'(done),   32'(t_done >= 0 && t >= t_done));
            if ((abort_idx > 0 && hs && idx == abort_idx) || (abort_t > 0 && t == abort_t)) begin
                rst     = 1'b1;
                phy_rdy = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (t_done >= 0 && t >= t_done + 4) break;
            if (t >= BUDGET) begin
                check_eq("timeout", 32'(t), 32'(t_done + 4));
                break;
            end
        end
    endtask

    initial begin
        bit ab;
        mr_tab  = MR;
        exp_edc = {{8{STRAP[1]}}, {8{STRAP[0]}}};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check_reset_vals("wait_phy");
        end

        run_seq(0, 0, 0, ab);
        do_reset(3);
        run_seq(1, 0, 0, ab);
        do_reset(2);
        run_seq(0, 2, 0, ab);
        check_eq("abort_taken", 32'(ab), 32'd1);
        do_reset(4);
        run_seq(0, 0, 0, ab);

        for (int k = 0; k < 8; k++) begin
            do_reset(int'($urandom_range(0, 5)));
            run_seq(2, 0, (k % 2 == 1) ? int'($urandom_range(5, 40)) : 0, ab);
        end
        do_reset(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
